// File: rtl/mandel_pkg.sv
// Shared types and default widths for the multi-engine Mandelbrot pixel scheduler.
package mandel_pkg;
    localparam int COORD_W = 11;
    localparam int COLOR_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               sof;
        logic               eol;
    } pix_slot_t;
endpackage

// File: rtl/mandel_engine_scheduler_raster.sv
// Raster walker: latches the frame size on load and steps x then y on advance.
module raster_counter #(
    parameter int COORD_W = 11
) (
    input  logic               out_stream_aclk,
    input  logic               periph_resetn,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] w_size,
    input  logic [COORD_W-1:0] h_size,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               sof,
    output logic               eol,
    output logic               last
);
    logic [COORD_W-1:0] w_m1;
    logic [COORD_W-1:0] h_m1;

    // A zero size is treated as one pixel, so the last index is 0 in both cases.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            w_m1 <= '0;
            h_m1 <= '0;
            x    <= '0;
            y    <= '0;
        end else if (load) begin
            w_m1 <= (w_size == '0) ? '0 : w_size - 1'b1;
            h_m1 <= (h_size == '0) ? '0 : h_size - 1'b1;
            x    <= '0;
            y    <= '0;
        end else if (advance) begin
            if (x == w_m1) begin
                x <= '0;
                y <= (y == h_m1) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign sof  = (x == '0) && (y == '0);
    assign eol  = (x == w_m1);
    assign last = eol && (y == h_m1);
endmodule

// File: rtl/mandel_engine_scheduler.sv
// Round-robin dispatch of raster pixels to replicated depth engines, with in-order
// collection through one result slot per lane onto a valid/ready pixel stream.
module mandel_engine_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int COORD_W     = 11,
    parameter int COLOR_W     = 24,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                           out_stream_aclk,
    input  logic                           periph_resetn,
    input  logic                           enable,
    input  logic [COORD_W-1:0]             x_size,
    input  logic [COORD_W-1:0]             y_size,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [NUM_ENGINES*COORD_W-1:0] eng_x,
    output logic [NUM_ENGINES*COORD_W-1:0] eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES*COLOR_W-1:0] eng_color,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [7:0]                     pix_r,
    output logic [7:0]                     pix_g,
    output logic [7:0]                     pix_b,
    output logic [COORD_W-1:0]             pix_x,
    output logic [COORD_W-1:0]             pix_y,
    output logic                           pix_sof,
    output logic                           pix_eol,
    output logic                           busy,
    output logic [FRAME_CNT_W-1:0]         frame_count,
    output logic                           err_spurious
);
    import mandel_pkg::*;

    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int PTR_N = 1 << PTR_W;
    typedef logic [PTR_W-1:0] ptr_t;

    sched_state_t       state;
    ptr_t               dptr;
    ptr_t               optr;
    logic [PTR_N-1:0]   lane_busy;
    logic [PTR_N-1:0]   slot_full;
    logic [PTR_N-1:0]   lane_sof;
    logic [PTR_N-1:0]   lane_eol;
    logic [COORD_W-1:0] lane_x     [PTR_N];
    logic [COORD_W-1:0] lane_y     [PTR_N];
    logic [COLOR_W-1:0] slot_color [PTR_N];

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_sof;
    logic               r_eol;
    logic               r_last;
    logic               frame_load;
    logic               dispatch;
    logic               consume;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == ptr_t'(NUM_ENGINES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign frame_load = (state == IDLE) && enable;
    assign dispatch   = (state == RUN) && !lane_busy[dptr] && !slot_full[dptr];
    assign consume    = slot_full[optr] && pix_ready;

    raster_counter #(.COORD_W(COORD_W)) u_raster (
        .out_stream_aclk (out_stream_aclk),
        .periph_resetn   (periph_resetn),
        .load            (frame_load),
        .advance         (dispatch),
        .w_size          (x_size),
        .h_size          (y_size),
        .x               (r_x),
        .y               (r_y),
        .sof             (r_sof),
        .eol             (r_eol),
        .last            (r_last)
    );

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state        <= IDLE;
            dptr         <= '0;
            optr         <= '0;
            frame_count  <= '0;
            err_spurious <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (dispatch && r_last) state <= DRAIN;
                DRAIN: begin
                    if (lane_busy == '0 && slot_full == '0) begin
                        frame_count <= frame_count + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (dispatch) dptr <= ptr_next(dptr);
            if (consume)  optr <= ptr_next(optr);
            if ((eng_done & ~lane_busy[NUM_ENGINES-1:0]) != '0) err_spurious <= 1'b1;
        end
    end

    // A lane's coordinates double as its slot coordinates: they are only rewritten
    // on dispatch, which requires the slot to be empty.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            eng_start <= '0;
            lane_busy <= '0;
            slot_full <= '0;
            lane_sof  <= '0;
            lane_eol  <= '0;
            for (int k = 0; k < PTR_N; k++) begin
                lane_x[k]     <= '0;
                lane_y[k]     <= '0;
                slot_color[k] <= '0;
            end
        end else begin
            eng_start <= '0;
            for (int k = 0; k < NUM_ENGINES; k++) begin
                if (dispatch && dptr == ptr_t'(k)) begin
                    eng_start[k] <= 1'b1;
                    lane_busy[k] <= 1'b1;
                    lane_x[k]    <= r_x;
                    lane_y[k]    <= r_y;
                    lane_sof[k]  <= r_sof;
                    lane_eol[k]  <= r_eol;
                end else if (eng_done[k] && lane_busy[k]) begin
                    lane_busy[k]  <= 1'b0;
                    slot_full[k]  <= 1'b1;
                    slot_color[k] <= eng_color[k*COLOR_W +: COLOR_W];
                end
                if (consume && optr == ptr_t'(k)) slot_full[k] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_lane_out
        assign eng_x[k*COORD_W +: COORD_W] = lane_x[k];
        assign eng_y[k*COORD_W +: COORD_W] = lane_y[k];
    end

    assign pix_valid = slot_full[optr];
    assign pix_r     = slot_color[optr][23:16];
    assign pix_g     = slot_color[optr][15:8];
    assign pix_b     = slot_color[optr][7:0];
    assign pix_x     = lane_x[optr];
    assign pix_y     = lane_y[optr];
    assign pix_sof   = lane_sof[optr];
    assign pix_eol   = lane_eol[optr];
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mandel_engine_scheduler.sv
// Scoreboard bench: a 4-lane and a 1-lane scheduler driven by behavioural engines.
module tb_mandel_engine_scheduler;
    typedef struct packed {
        logic [23:0] c;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
    } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // 4-lane instance signals
    logic        rstn4, en4, r4, v4, sof4, eol4, busy4, err4;
    logic [10:0] xs4, ys4, px4, py4;
    logic [3:0]  start4, done4, done4_m, spur4;
    logic [43:0] ex4, ey4;
    logic [95:0] col4;
    logic [7:0]  pr4, pg4, pb4;
    logic [15:0] fc4;
    int          lat4 [4];
    int          cnt4 [4];
    int          acc4 = 0;
    pix_t        q4 [$];

    // 1-lane instance signals
    logic        rstn1, en1, r1, v1, sof1, eol1, busy1, err1;
    logic [10:0] xs1, ys1, px1, py1, ex1, ey1;
    logic [0:0]  start1, done1;
    logic [23:0] col1;
    logic [7:0]  pr1, pg1, pb1;
    logic [15:0] fc1;
    int          lat1 = 2;
    int          cnt1 = 0;
    int          starts1 = 0;
    pix_t        q1 [$];

    assign done4 = done4_m | spur4;

    mandel_engine_scheduler #(.NUM_ENGINES(4)) dut4 (
        .out_stream_aclk(clk), .periph_resetn(rstn4), .enable(en4),
        .x_size(xs4), .y_size(ys4), .eng_start(start4), .eng_x(ex4), .eng_y(ey4),
        .eng_done(done4), .eng_color(col4), .pix_valid(v4), .pix_ready(r4),
        .pix_r(pr4), .pix_g(pg4), .pix_b(pb4), .pix_x(px4), .pix_y(py4),
        .pix_sof(sof4), .pix_eol(eol4), .busy(busy4), .frame_count(fc4),
        .err_spurious(err4)
    );

    mandel_engine_scheduler #(.NUM_ENGINES(1)) dut1 (
        .out_stream_aclk(clk), .periph_resetn(rstn1), .enable(en1),
        .x_size(xs1), .y_size(ys1), .eng_start(start1), .eng_x(ex1), .eng_y(ey1),
        .eng_done(done1), .eng_color(col1), .pix_valid(v1), .pix_ready(r1),
        .pix_r(pr1), .pix_g(pg1), .pix_b(pb1), .pix_x(px1), .pix_y(py1),
        .pix_sof(sof1), .pix_eol(eol1), .busy(busy1), .frame_count(fc1),
        .err_spurious(err1)
    );

    function automatic logic [23:0] colf(input logic [10:0] x, input logic [10:0] y);
        return {x[7:0] ^ 8'h5A, y[7:0] + 8'h11, x[3:0], y[3:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                q4.push_back(pix_t'({colf(11'(x), 11'(y)), 11'(x), 11'(y),
                                     (x == 0 && y == 0), (x == w - 1)}));
    endtask

    task automatic set_lat4(input int a, input int b, input int c, input int d);
        lat4[0] = a; lat4[1] = b; lat4[2] = c; lat4[3] = d;
    endtask

    task automatic start4_frame(input int w, input int h);
        xs4 = 11'(w);
        ys4 = 11'(h);
        en4 = 1'b1;
        tick();
        en4 = 1'b0;
        chk("busy4_after_start", 64'(busy4), 64'd1);
    endtask

    task automatic wait_idle4(input string name);
        for (int i = 0; i < 500 && busy4; i++) tick();
        chk(name, 64'(busy4), 64'd0);
        chk({name, "_queue_empty"}, 64'(q4.size()), 64'd0);
    endtask

    // Behavioural engines: done arrives lat negedges after the start pulse is seen.
    initial begin
        done4_m = '0;
        col4    = '0;
        for (int k = 0; k < 4; k++) cnt4[k] = 0;
        forever begin
            @(negedge clk);
            done4_m = '0;
            if (!rstn4) begin
                for (int k = 0; k < 4; k++) cnt4[k] = 0;
                continue;
            end
            for (int k = 0; k < 4; k++) begin
                if (cnt4[k] > 0) begin
                    cnt4[k]--;
                    if (cnt4[k] == 0) begin
                        done4_m[k] = 1'b1;
                        col4[k*24 +: 24] = colf(ex4[k*11 +: 11], ey4[k*11 +: 11]);
                    end
                end
                if (start4[k]) begin
                    chk("lane4_idle_at_start", 64'(cnt4[k] == 0 && !done4_m[k]), 64'd1);
                    cnt4[k] = lat4[k];
                end
            end
        end
    end

    initial begin
        done1 = '0;
        col1  = '0;
        forever begin
            @(negedge clk);
            done1 = '0;
            if (!rstn1) begin
                cnt1 = 0;
                continue;
            end
            if (cnt1 > 0) begin
                cnt1--;
                if (cnt1 == 0) begin
                    done1 = 1'b1;
                    col1  = colf(ex1, ey1);
                end
            end
            if (start1[0]) begin
                starts1++;
                chk("lane1_idle_at_start", 64'(cnt1 == 0 && !done1[0]), 64'd1);
                cnt1 = lat1;
            end
        end
    end

    // Output monitors: pop the scoreboard on every accepted pixel.
    initial begin
        pix_t got, held, want;
        logic stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rstn4) begin
                stall_prev = 1'b0;
                continue;
            end
            got = {pr4, pg4, pb4, px4, py4, sof4, eol4};
            if (stall_prev) chk("hold_stable4", 64'({v4, got}), 64'({1'b1, held}));
            if (v4 && r4) begin
                acc4++;
                if (q4.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pixel4: got (%0d,%0d), required no pixel", px4, py4);
                end else begin
                    want = q4.pop_front();
                    chk("pixel4", 64'(got), 64'(want));
                end
            end
            stall_prev = v4 && !r4;
            held = got;
        end
    end

    initial begin
        pix_t got, want;
        forever begin
            @(negedge clk);
            if (rstn1 && v1 && r1) begin
                got = {pr1, pg1, pb1, px1, py1, sof1, eol1};
                if (q1.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pixel1: got (%0d,%0d), required no pixel", px1, py1);
                end else begin
                    want = q1.pop_front();
                    chk("pixel1", 64'(got), 64'(want));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rstn4 = 1'b0; en4 = 1'b0; r4 = 1'b1; xs4 = '0; ys4 = '0; spur4 = '0;
        rstn1 = 1'b0; en1 = 1'b0; r1 = 1'b1; xs1 = '0; ys1 = '0;
        set_lat4(7, 3, 5, 1);
        @(negedge clk);
        chk("reset_busy4", 64'(busy4), 64'd0);
        chk("reset_valid4", 64'(v4), 64'd0);
        chk("reset_fc4", 64'(fc4), 64'd0);
        chk("reset_outs4", 64'({start4, ex4, err4, px4, sof4, eol4}), 64'd0);
        chk("reset_outs1", 64'({busy1, v1, fc1, start1, err1}), 64'd0);
        tick();
        rstn4 = 1'b1;
        rstn1 = 1'b1;
        tick();

        // Single lane, 3x1: dispatches must be strictly sequential.
        for (int x = 0; x < 3; x++)
            q1.push_back(pix_t'({colf(11'(x), 11'd0), 11'(x), 11'd0, (x == 0), (x == 2)}));
        xs1 = 11'd3; ys1 = 11'd1; en1 = 1'b1;
        tick();
        en1 = 1'b0;
        for (int i = 0; i < 200 && busy1; i++) tick();
        chk("n1_idle", 64'(busy1), 64'd0);
        chk("n1_starts", 64'(starts1), 64'd3);
        chk("n1_frame_count", 64'(fc1), 64'd1);
        chk("n1_queue_empty", 64'(q1.size()), 64'd0);

        // Frame A: 4x2, mixed latencies, always ready.
        push4(4, 2);
        start4_frame(4, 2);
        wait_idle4("frameA_idle");
        chk("frameA_count", 64'(fc4), 64'd1);

        // Frame B: downstream stalls for 10 cycles after two pixels.
        set_lat4(2, 4, 1, 3);
        push4(4, 2);
        base = acc4;
        start4_frame(4, 2);
        for (int i = 0; i < 200 && acc4 < base + 2; i++) tick();
        r4 = 1'b0;
        repeat (10) tick();
        chk("frameB_stall_valid", 64'(v4), 64'd1);
        r4 = 1'b1;
        wait_idle4("frameB_idle");
        chk("frameB_count", 64'(fc4), 64'd2);

        // Spurious done on idle lane 2, then a normal frame.
        chk("spur_before", 64'(err4), 64'd0);
        spur4 = 4'b0100;
        tick();
        spur4 = '0;
        tick();
        chk("spur_set", 64'(err4), 64'd1);
        set_lat4(2, 6, 1, 4);
        push4(4, 2);
        start4_frame(4, 2);
        wait_idle4("frameC_idle");
        chk("frameC_count", 64'(fc4), 64'd3);
        chk("spur_sticky", 64'(err4), 64'd1);

        // Reset while three lanes are busy, then restart from (0,0).
        set_lat4(7, 3, 5, 1);
        start4_frame(4, 2);
        for (int i = 0; i < 50 && start4 != 4'b0100; i++) tick();
        rstn4 = 1'b0;
        q4.delete();
        @(negedge clk);
        chk("midreset_busy", 64'(busy4), 64'd0);
        chk("midreset_outs", 64'({v4, start4, fc4, err4, px4, py4, ex4}), 64'd0);
        tick();
        rstn4 = 1'b1;
        tick();
        push4(4, 2);
        start4_frame(4, 2);
        wait_idle4("frameD_idle");
        chk("frameD_count", 64'(fc4), 64'd1);
        chk("frameD_no_err", 64'(err4), 64'd0);

        // Zero sizes with enable held: two single-pixel frames.
        rstn4 = 1'b0;
        tick();
        rstn4 = 1'b1;
        push4(1, 1);
        push4(1, 1);
        xs4 = '0; ys4 = '0; en4 = 1'b1;
        for (int i = 0; i < 200 && fc4 < 16'd2; i++) tick();
        en4 = 1'b0;
        wait_idle4("zero_idle");
        repeat (3) tick();
        chk("zero_count", 64'(fc4), 64'd2);
        chk("zero_stays_idle", 64'(busy4), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
